alu16_reg: RTL and testbench



---
 rtl/alu16_reg.sv | 131 +++++++++++++
 tb/tb_alu16_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu16_reg.sv
`default_nettype none
// ============================================================================
// Module   : alu16_reg
// Brief    : 16-bit ALU (arithmetic, logic, shift/rotate) with registered
//            result and Z/N/C/V flags. Optional MUL opcode via ALU_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu16_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ext_cin,
    input  logic [4:0]       ALUop,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam logic [4:0] c_OP_ADD  = 5'b00000;
    localparam logic [4:0] c_OP_ADC  = 5'b00001;
    localparam logic [4:0] c_OP_SUB  = 5'b00010;
    localparam logic [4:0] c_OP_SBC  = 5'b00011;
    localparam logic [4:0] c_OP_AND  = 5'b00100;
    localparam logic [4:0] c_OP_OR   = 5'b00101;
    localparam logic [4:0] c_OP_XOR  = 5'b00110;
    localparam logic [4:0] c_OP_NOT  = 5'b00111;
    localparam logic [4:0] c_OP_LSL  = 5'b01000;
    localparam logic [4:0] c_OP_LSR  = 5'b01001;
    localparam logic [4:0] c_OP_ASR  = 5'b01010;
    localparam logic [4:0] c_OP_ROL  = 5'b01011;
    localparam logic [4:0] c_OP_ROR  = 5'b01100;
    localparam logic [4:0] c_OP_INC  = 5'b01101;
    localparam logic [4:0] c_OP_DEC  = 5'b01110;
    localparam logic [4:0] c_OP_PASS = 5'b01111;
`ifdef ALU_MUL_EN
    localparam logic [4:0] c_OP_MUL  = 5'b10000;
`endif

    logic [WIDTH-1:0] w_opb;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_add_v;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] r_y;
    logic             r_z;
    logic             r_n;
    logic             r_c;
    logic             r_v;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = A * B;
`endif

    // All add/subtract/inc/dec ops share one adder: A + w_opb + w_cin.
    always_comb begin
        w_opb = B;
        w_cin = 1'b0;
        case (ALUop)
            c_OP_ADC: w_cin = Ext_cin;
            c_OP_SUB: begin w_opb = ~B; w_cin = 1'b1;    end
            c_OP_SBC: begin w_opb = ~B; w_cin = Ext_cin; end
            c_OP_INC: begin w_opb = '0; w_cin = 1'b1;    end
            c_OP_DEC: begin w_opb = '1; w_cin = 1'b0;    end
            default:  ;
        endcase
    end

    assign w_sum   = {1'b0, A} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
    assign w_add_v = (A[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        w_y = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (ALUop)
            c_OP_ADD, c_OP_ADC, c_OP_SUB, c_OP_SBC, c_OP_INC, c_OP_DEC: begin
                w_y = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = w_add_v;
            end
            c_OP_AND:  w_y = A & B;
            c_OP_OR:   w_y = A | B;
            c_OP_XOR:  w_y = A ^ B;
            c_OP_NOT:  w_y = ~A;
            c_OP_LSL:  begin w_y = {A[WIDTH-2:0], 1'b0};       w_c = A[WIDTH-1]; end
            c_OP_LSR:  begin w_y = {1'b0, A[WIDTH-1:1]};       w_c = A[0];       end
            c_OP_ASR:  begin w_y = {A[WIDTH-1], A[WIDTH-1:1]}; w_c = A[0];       end
            c_OP_ROL:  begin w_y = {A[WIDTH-2:0], A[WIDTH-1]}; w_c = A[WIDTH-1]; end
            c_OP_ROR:  begin w_y = {A[0], A[WIDTH-1:1]};       w_c = A[0];       end
            c_OP_PASS: w_y = A;
`ifdef ALU_MUL_EN
            c_OP_MUL:  begin
                w_y = w_prod[WIDTH-1:0];
                w_c = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
            r_z <= 1'b1;
            r_n <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else begin
            r_y <= w_y;
            r_z <= (w_y == '0);
            r_n <= w_y[WIDTH-1];
            r_c <= w_c;
            r_v <= w_v;
        end
    end

    assign y = r_y;
    assign z = r_z;
    assign n = r_n;
    assign c = r_c;
    assign v = r_v;

endmodule
`default_nettype wire

// File: tb/tb_alu16_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu16_reg
// Brief    : Table-driven self-checking bench for alu16_reg (optionally with
//            ALU_MUL_EN), plus hand sequences for asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_reg;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] ey;
        logic        ez;
        logic        en;
        logic        ec;
        logic        ev;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ext_cin;
    logic [4:0]  ALUop;
    logic [15:0] y;
    logic        z;
    logic        n;
    logic        c;
    logic        v;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    alu16_reg #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Ext_cin (Ext_cin),
        .ALUop   (ALUop),
        .y       (y),
        .z       (z),
        .n       (n),
        .c       (c),
        .v       (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] ey,
                         input logic ez, input logic en, input logic ec, input logic ev);
        checks++;
        if ({y, z, n, c, v} !== {ey, ez, en, ec, ev}) begin
            errors++;
            $display("FAIL %s: got y=%h z%b n%b c%b v%b, expected y=%h z%b n%b c%b v%b",
                     name, y, z, n, c, v, ey, ez, en, ec, ev);
        end
    endtask

    task automatic apply(input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        ALUop   = op;
        A       = a;
        B       = b;
        Ext_cin = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] ey,
                           input logic ez, input logic en, input logic ec, input logic ev);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.cin = cin;
        t.ey = ey; t.ez = ez; t.en = en; t.ec = ec; t.ev = ev;
        vecs.push_back(t);
    endtask

    initial begin
        //        op        A        B        cin  y        z  n  c  v
        add_vec(5'b00010, 16'd15,  16'd10,  1'b0, 16'd5,   0, 0, 1, 0);
        add_vec(5'b00010, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 0, 1, 0, 0);
        add_vec(5'b00010, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 0, 1, 1);
        add_vec(5'b00100, 16'h00F0, 16'h000F, 1'b0, 16'h0000, 1, 0, 0, 0);
        add_vec(5'b00101, 16'h00F0, 16'h000F, 1'b0, 16'h00FF, 0, 0, 0, 0);
        add_vec(5'b00110, 16'h00AA, 16'h0055, 1'b0, 16'h00FF, 0, 0, 0, 0);
        add_vec(5'b00111, 16'h000F, 16'h1234, 1'b0, 16'hFFF0, 0, 1, 0, 0);
        add_vec(5'b01000, 16'h00FF, 16'h0000, 1'b0, 16'h01FE, 0, 0, 0, 0);
        add_vec(5'b01001, 16'hFF00, 16'h0000, 1'b0, 16'h7F80, 0, 0, 0, 0);
        add_vec(5'b01010, 16'h8001, 16'h0000, 1'b0, 16'hC000, 0, 1, 1, 0);
        add_vec(5'b01011, 16'h8000, 16'h0000, 1'b0, 16'h0001, 0, 0, 1, 0);
        add_vec(5'b01100, 16'h0001, 16'h0000, 1'b1, 16'h8000, 0, 1, 1, 0);
        add_vec(5'b00001, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 1, 0);
        add_vec(5'b00000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1);
        add_vec(5'b00000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1, 0, 1, 0);
        add_vec(5'b00000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 0, 1, 1);
        add_vec(5'b00011, 16'd5,   16'd3,   1'b1, 16'd2,   0, 0, 1, 0);
        add_vec(5'b00011, 16'd5,   16'd3,   1'b0, 16'd1,   0, 0, 1, 0);
        add_vec(5'b01101, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 1, 0);
        add_vec(5'b01101, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 0, 1, 0, 1);
        add_vec(5'b01110, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 0, 1, 0, 0);
        add_vec(5'b01110, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 0, 0, 1, 1);
        add_vec(5'b01111, 16'h8001, 16'hFFFF, 1'b1, 16'h8001, 0, 1, 0, 0);
        add_vec(5'b11111, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1, 0, 0, 0);
`ifdef ALU_MUL_EN
        add_vec(5'b10000, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1, 0, 1, 0);
        add_vec(5'b10000, 16'd3,   16'd4,   1'b0, 16'd12,  0, 0, 0, 0);
        add_vec(5'b10000, 16'hFFFF, 16'h0002, 1'b0, 16'hFFFE, 0, 1, 1, 0);
`else
        add_vec(5'b10000, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1, 0, 0, 0);
        add_vec(5'b10000, 16'd3,   16'd4,   1'b0, 16'h0000, 1, 0, 0, 0);
`endif

        rst_n   = 1'b0;
        A       = 16'h0;
        B       = 16'h0;
        Ext_cin = 1'b0;
        ALUop   = 5'b00000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 1, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(5'b00000, 16'd5, 16'd10, 1'b0);
        check("add_after_reset", 16'd15, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("vec%0d_op%b", i, vecs[i].op),
                  vecs[i].ey, vecs[i].ez, vecs[i].en, vecs[i].ec, vecs[i].ev);
        end

        // Mid-cycle asynchronous reset must clear a nonzero result at once.
        apply(5'b00000, 16'h7FFF, 16'h0001, 1'b0);
        check("pre_async_reset", 16'h8000, 0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 16'h0000, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 16'h0000, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(5'b00000, 16'd5, 16'd10, 1'b0);
        check("add_after_async_reset", 16'd15, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
